// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the architectural PC, keeps
// at most one imem request in flight, squashes fetches made stale by a
// redirect and hands instructions to decode through a one-entry buffer.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  // halt_q: a misaligned redirect arrived while a response was still owed;
  // enter S_HALT once that response has been swallowed.
  logic        halt_q, halt_d;
  logic        vld_q, vld_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic buf_free, hs, misalign;

  // Requests go out only when the buffer will have room for the answer.
  assign buf_free       = !vld_q || !stall;
  assign imem_req_valid = rst_n && (state_q == S_REQ) && buf_free;
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign misalign       = redirect_pc[1:0] != 2'b00;

  assign if_valid     = vld_q;
  assign if_pc        = ipc_q;
  assign if_instr     = instr_q;
  assign if_pc_plus4  = ipc_q + 32'd4;
  assign misalign_err = err_q;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
      drop_q   <= 1'b0;
      halt_q   <= 1'b0;
      vld_q    <= 1'b0;
      ipc_q    <= 32'd0;
      instr_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      halt_q   <= halt_d;
      vld_q    <= vld_d;
      ipc_q    <= ipc_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
    end
  end

  // Next-state: normal fetch flow first, redirect applied last so it wins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    halt_d   = halt_q;
    vld_d    = vld_q;
    ipc_d    = ipc_q;
    instr_d  = instr_q;
    err_d    = err_q;

    if (vld_q && !stall) vld_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (!drop_q) begin
            vld_d   = 1'b1;
            ipc_d   = req_pc_q;
            instr_d = imem_rsp_data;
          end
          drop_d  = 1'b0;
          state_d = halt_q ? S_HALT : S_REQ;
        end
      end
      default: ;
    endcase

    if (redirect_valid) begin
      // Flush the buffer, including a response landing this very cycle.
      vld_d = 1'b0;
      if (misalign) begin
        err_d = 1'b1;
        pc_d  = pc_q;
      end else begin
        pc_d = redirect_pc;
      end
      if (hs || (state_q == S_WAIT && !imem_rsp_valid)) begin
        // A response is still owed: mark it stale; halt after it if misaligned.
        drop_d = 1'b1;
        if (misalign) halt_d = 1'b1;
      end else if (misalign) begin
        state_d = S_HALT;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench. The driver plays instruction memory and
// the next-PC logic and predicts, per accepted request, whether its
// instruction must reach decode; the monitor checks each instruction as it
// appears in the output buffer against that queue.
module tb_fetch_ctrl;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc, if_instr, if_pc_plus4;
  logic        misalign_err;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

  ent_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;

  // Reference state (transaction level).
  logic [31:0] exp_pc;
  logic        halted_m, err_m;
  logic        outst, dirty;
  logic [31:0] out_addr;
  int          cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc   = 32'h0000_0000;
    halted_m = 1'b0;
    err_m    = 1'b0;
    outst    = 1'b0;
    dirty    = 1'b0;
    cnt      = 0;
    exp_q.delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk); #2;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One random phase: probabilities in percent; max response latency.
  task automatic run_phase(input int n, input int p_stall, input int p_redir,
                           input int p_rdy, input int p_mis, input int max_lat);
    logic hs, rsp, mis;
    int   r;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); #2;
      stall          = ($urandom_range(0, 99) < p_stall);
      imem_req_ready = ($urandom_range(0, 99) < p_rdy);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      r = $urandom_range(0, 99);
      if (r < p_mis)
        redirect_pc = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
      else if (r < 30)
        redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else
        redirect_pc = $urandom & 32'h0000_FFFC;
      imem_rsp_valid = outst && (cnt == 1);
      imem_rsp_data  = imem_rsp_valid ? mem_word(out_addr) : $urandom;
      #1;
      hs  = imem_req_valid && imem_req_ready;
      rsp = imem_rsp_valid;
      mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
      chk("req_protocol", {31'd0, imem_req_valid && (outst || halted_m || (stall && if_valid))}, 32'd0);
      if (rsp) begin
        if (!dirty && !redirect_valid) exp_q.push_back('{pc: out_addr, instr: mem_word(out_addr)});
        outst = 1'b0;
      end else if (outst) begin
        cnt--;
        if (redirect_valid) dirty = 1'b1;
      end
      if (hs) begin
        chk("req_addr", imem_req_addr, exp_pc);
        out_addr = imem_req_addr;
        outst    = 1'b1;
        dirty    = redirect_valid;
        cnt      = $urandom_range(1, max_lat);
        exp_pc   = exp_pc + 32'd4;
      end
      if (redirect_valid && !mis) exp_pc = redirect_pc;
      if (mis) begin halted_m = 1'b1; err_m = 1'b1; end
    end
  endtask

  // Monitor: checks the output buffer each negedge.
  initial begin : monitor
    logic        prev_v, consumed;
    logic [31:0] prev_pc, prev_instr;
    ent_t        e;
    prev_v = 1'b0; prev_pc = 32'd0; prev_instr = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_state", {28'd0, if_valid, misalign_err, imem_req_valid, 1'b0}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        prev_v = 1'b0;
        continue;
      end
      consumed = prev_v && (!stall || redirect_valid);
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, err_m});
      if (redirect_valid) chk("flush_on_redirect", {31'd0, if_valid}, 32'd0);
      if (prev_v && !consumed) begin
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_pc", if_pc, prev_pc);
        chk("hold_instr", if_instr, prev_instr);
      end else if (if_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_pc", if_pc, 32'hDEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          n_deliv++;
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
          chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
        end
      end
      prev_v = if_valid; prev_pc = if_pc; prev_instr = if_instr;
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    out_addr = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    // Free run, single-cycle memory: 0x0, 0x4, 0x8, ...
    run_phase(12, 0, 0, 100, 0, 1);
    // Heavy back-pressure.
    run_phase(60, 60, 0, 100, 0, 2);
    // Redirects, including near the top of the address space (wrap).
    run_phase(250, 25, 10, 70, 0, 3);
    // Misaligned redirects (halt), recovered by async reset.
    for (int k = 0; k < 6; k++) begin
      run_phase(150, 25, 8, 70, 6, 3);
      reset_pulse();
    end
    run_phase(100, 20, 10, 80, 0, 2);
    repeat (3) @(negedge clk);
    chk("deliveries_seen", {31'd0, n_deliv > 50}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
